// File: rtl/branch_history_tracker.sv
// Speculative global-history owner for gshare: records predictions, restores history on mispredict, emits retire-time training writes.
// Latency: bhr, mispredict and wr_* update one cycle after the triggering handshake; ready/tag outputs are combinational from state.
// Backpressure: pred_ready drops when all NUM_INFLIGHT slots are occupied; retire_ready waits for the head to resolve.
// Optional: define BRANCH_TRACKER_STATS_EN to add stat_retired / stat_mispredicts counters.

`ifndef BRANCH_HISTORY_TABLE_SIZE
`define BRANCH_HISTORY_TABLE_SIZE 16
`endif

module branch_history_tracker #(
    parameter int DEPTH        = `BRANCH_HISTORY_TABLE_SIZE,
    parameter int NUM_INFLIGHT = 8,
    localparam int LOG_DEPTH   = $clog2(DEPTH),
    localparam int TAG_W       = $clog2(NUM_INFLIGHT)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 pred_valid,
    input  logic                 pred_taken,
    input  logic [LOG_DEPTH-1:0] pred_index,
    output logic                 pred_ready,
    output logic [TAG_W-1:0]     pred_tag,
    output logic [LOG_DEPTH-1:0] bhr,
    input  logic                 resolve_valid,
    input  logic [TAG_W-1:0]     resolve_tag,
    input  logic                 resolve_taken,
    output logic                 mispredict,
    output logic [TAG_W-1:0]     mispredict_tag,
    input  logic                 retire_valid,
    output logic                 retire_ready,
    output logic                 wr_en,
    output logic                 wr_taken,
    output logic [LOG_DEPTH-1:0] wr_index,
    output logic [TAG_W:0]       count
`ifdef BRANCH_TRACKER_STATS_EN
    ,
    output logic [31:0]          stat_retired,
    output logic [31:0]          stat_mispredicts
`endif
);

    localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(NUM_INFLIGHT);

    // Per-slot state; bit vectors for flags, arrays for the multi-bit fields.
    logic [NUM_INFLIGHT-1:0] valid_q, valid_d;
    logic [NUM_INFLIGHT-1:0] resolved_q, resolved_d;
    logic [NUM_INFLIGHT-1:0] pt_q, pt_d;
    logic [NUM_INFLIGHT-1:0] at_q, at_d;
    logic [LOG_DEPTH-1:0]    index_q [NUM_INFLIGHT];
    logic [LOG_DEPTH-1:0]    index_d [NUM_INFLIGHT];
    logic [LOG_DEPTH-1:0]    snap_q  [NUM_INFLIGHT];
    logic [LOG_DEPTH-1:0]    snap_d  [NUM_INFLIGHT];

    logic [TAG_W-1:0]     head_q, head_d;
    logic [TAG_W-1:0]     tail_q, tail_d;
    logic [TAG_W:0]       count_q, count_d;
    logic [LOG_DEPTH-1:0] bhr_q, bhr_d;
    logic                 mispredict_q, mispredict_d;
    logic [TAG_W-1:0]     mispredict_tag_q, mispredict_tag_d;
    logic                 wr_en_q, wr_en_d;
    logic                 wr_taken_q, wr_taken_d;
    logic [LOG_DEPTH-1:0] wr_index_q, wr_index_d;
`ifdef BRANCH_TRACKER_STATS_EN
    logic [31:0]          stat_retired_q, stat_retired_d;
    logic [31:0]          stat_mispredicts_q, stat_mispredicts_d;
`endif

    logic             res_hit;
    logic             mis_now;
    logic             do_alloc;
    logic             do_retire;
    logic [TAG_W-1:0] off_t;

    // Handshake decode: everything derives from registered state plus this cycle's inputs.
    always_comb begin
        pred_ready   = (count_q != FULL_CNT);
        pred_tag     = tail_q;
        retire_ready = valid_q[head_q] && resolved_q[head_q];
        res_hit      = resolve_valid && valid_q[resolve_tag];
        mis_now      = res_hit && (resolve_taken != pt_q[resolve_tag]);
        do_alloc     = pred_valid && pred_ready && !mis_now;
        do_retire    = retire_valid && retire_ready;
        // Age of the resolving slot relative to the oldest entry.
        off_t        = TAG_W'(resolve_tag - head_q);
    end

    // Next-state: resolve, allocate, retire, then a mispredict squash overrides tail/count/bhr.
    always_comb begin
        valid_d          = valid_q;
        resolved_d       = resolved_q;
        pt_d             = pt_q;
        at_d             = at_q;
        index_d          = index_q;
        snap_d           = snap_q;
        head_d           = head_q;
        tail_d           = tail_q;
        count_d          = count_q + {{TAG_W{1'b0}}, do_alloc} - {{TAG_W{1'b0}}, do_retire};
        bhr_d            = bhr_q;
        mispredict_d     = mis_now;
        mispredict_tag_d = mispredict_tag_q;
        wr_en_d          = do_retire;
        wr_taken_d       = wr_taken_q;
        wr_index_d       = wr_index_q;
`ifdef BRANCH_TRACKER_STATS_EN
        stat_retired_d     = stat_retired_q + {31'd0, do_retire};
        stat_mispredicts_d = stat_mispredicts_q + {31'd0, mis_now};
`endif

        if (res_hit) begin
            resolved_d[resolve_tag] = 1'b1;
            at_d[resolve_tag]       = resolve_taken;
        end

        if (do_alloc) begin
            valid_d[tail_q]    = 1'b1;
            resolved_d[tail_q] = 1'b0;
            pt_d[tail_q]       = pred_taken;
            index_d[tail_q]    = pred_index;
            snap_d[tail_q]     = bhr_q;
            tail_d             = tail_q + 1'b1;
            bhr_d              = (bhr_q << 1) | LOG_DEPTH'(pred_taken);
        end

        // Training data comes from the head as it stood before this cycle's updates.
        if (do_retire) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
            wr_taken_d      = at_q[head_q];
            wr_index_d      = index_q[head_q];
        end

        if (mis_now) begin
            mispredict_tag_d = resolve_tag;
            bhr_d            = (snap_q[resolve_tag] << 1) | LOG_DEPTH'(resolve_taken);
            tail_d           = resolve_tag + 1'b1;
            // Entries are contiguous from head, so anything older-than-tail but
            // with a larger age than the resolving slot is younger and dies.
            for (int i = 0; i < NUM_INFLIGHT; i++) begin
                if (TAG_W'(TAG_W'(i) - head_q) > off_t) begin
                    valid_d[i] = 1'b0;
                end
            end
            // Measured from the pre-retire head; a same-cycle retire removes one more.
            count_d = {1'b0, off_t} + (TAG_W+1)'(1) - {{TAG_W{1'b0}}, do_retire};
        end
    end

    // State registers; reset discards every in-flight entry at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q          <= '0;
            resolved_q       <= '0;
            pt_q             <= '0;
            at_q             <= '0;
            for (int i = 0; i < NUM_INFLIGHT; i++) begin
                index_q[i] <= '0;
                snap_q[i]  <= '0;
            end
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            bhr_q            <= '0;
            mispredict_q     <= 1'b0;
            mispredict_tag_q <= '0;
            wr_en_q          <= 1'b0;
            wr_taken_q       <= 1'b0;
            wr_index_q       <= '0;
`ifdef BRANCH_TRACKER_STATS_EN
            stat_retired_q     <= '0;
            stat_mispredicts_q <= '0;
`endif
        end else begin
            valid_q          <= valid_d;
            resolved_q       <= resolved_d;
            pt_q             <= pt_d;
            at_q             <= at_d;
            index_q          <= index_d;
            snap_q           <= snap_d;
            head_q           <= head_d;
            tail_q           <= tail_d;
            count_q          <= count_d;
            bhr_q            <= bhr_d;
            mispredict_q     <= mispredict_d;
            mispredict_tag_q <= mispredict_tag_d;
            wr_en_q          <= wr_en_d;
            wr_taken_q       <= wr_taken_d;
            wr_index_q       <= wr_index_d;
`ifdef BRANCH_TRACKER_STATS_EN
            stat_retired_q     <= stat_retired_d;
            stat_mispredicts_q <= stat_mispredicts_d;
`endif
        end
    end

    assign bhr            = bhr_q;
    assign count          = count_q;
    assign mispredict     = mispredict_q;
    assign mispredict_tag = mispredict_tag_q;
    assign wr_en          = wr_en_q;
    assign wr_taken       = wr_taken_q;
    assign wr_index       = wr_index_q;
`ifdef BRANCH_TRACKER_STATS_EN
    assign stat_retired     = stat_retired_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_history_tracker.sv
// Bench for branch_history_tracker: directed vector table, corner sequences, randomized run vs. queue model.
// Latency: inputs applied 1 time unit after a rising edge, outputs compared 1 unit after the next.
// Backpressure: model mirrors pred_ready / retire_ready from its own queue occupancy.

module tb_branch_history_tracker;

    logic       clock = 1'b0;
    logic       reset;
    logic       pred_valid, pred_taken;
    logic [3:0] pred_index;
    logic       pred_ready;
    logic [2:0] pred_tag;
    logic [3:0] bhr;
    logic       resolve_valid;
    logic [2:0] resolve_tag;
    logic       resolve_taken;
    logic       mispredict;
    logic [2:0] mispredict_tag;
    logic       retire_valid, retire_ready;
    logic       wr_en, wr_taken;
    logic [3:0] wr_index;
    logic [3:0] count;
`ifdef BRANCH_TRACKER_STATS_EN
    logic [31:0] stat_retired, stat_mispredicts;
`endif

    branch_history_tracker #(.DEPTH(16), .NUM_INFLIGHT(8)) dut (
        .clock(clock), .reset(reset),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_index(pred_index),
        .pred_ready(pred_ready), .pred_tag(pred_tag), .bhr(bhr),
        .resolve_valid(resolve_valid), .resolve_tag(resolve_tag), .resolve_taken(resolve_taken),
        .mispredict(mispredict), .mispredict_tag(mispredict_tag),
        .retire_valid(retire_valid), .retire_ready(retire_ready),
        .wr_en(wr_en), .wr_taken(wr_taken), .wr_index(wr_index),
        .count(count)
`ifdef BRANCH_TRACKER_STATS_EN
        , .stat_retired(stat_retired), .stat_mispredicts(stat_mispredicts)
`endif
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: in-flight branches as an ordered queue, oldest first.
    typedef struct {
        logic       pt;
        logic       at;
        logic       res;
        logic [3:0] idx;
        logic [3:0] snap;
    } ent_t;

    ent_t mq[$];
    int   m_head;
    int   m_bhr;
    logic e_mis;
    int   e_mtag;
    logic e_wr;
    logic e_wrt;
    int   e_wri;

    task automatic model_clear();
        mq.delete();
        m_head = 0;
        m_bhr  = 0;
        e_mis  = 0;
        e_mtag = 0;
        e_wr   = 0;
        e_wrt  = 0;
        e_wri  = 0;
    endtask

    task automatic model_step(input logic pv, input logic pt, input logic [3:0] pidx,
                              input logic rv, input logic [2:0] rtag, input logic rt,
                              input logic retv);
        int   sz;
        int   pos;
        int   keep;
        logic hit, mis, alloc, ret;
        logic [3:0] snap_t;
        ent_t e;
        sz     = mq.size();
        alloc  = pv && (sz < 8);
        ret    = retv && (sz > 0) && mq[0].res;
        pos    = ((int'(rtag) - m_head) % 8 + 8) % 8;
        hit    = rv && (pos < sz);
        mis    = 1'b0;
        snap_t = 4'd0;
        if (hit) begin
            e      = mq[pos];
            mis    = (rt != e.pt);
            snap_t = e.snap;
        end
        e_mis = mis;
        if (mis) e_mtag = int'(rtag);
        e_wr = ret;
        if (ret) begin
            e_wrt = mq[0].at;
            e_wri = int'(mq[0].idx);
        end
        if (hit) begin
            e     = mq[pos];
            e.res = 1'b1;
            e.at  = rt;
            mq[pos] = e;
        end
        if (ret) begin
            void'(mq.pop_front());
            m_head = (m_head + 1) % 8;
            pos    = pos - 1;
        end
        if (mis) begin
            keep = pos + 1;
            while (mq.size() > keep) void'(mq.pop_back());
            m_bhr = ((int'(snap_t) * 2) + int'(rt)) % 16;
        end else if (alloc) begin
            e.pt   = pt;
            e.at   = 1'b0;
            e.res  = 1'b0;
            e.idx  = pidx;
            e.snap = 4'(m_bhr);
            mq.push_back(e);
            m_bhr = ((m_bhr * 2) + int'(pt)) % 16;
        end
    endtask

    task automatic check_model();
        int sz;
        sz = mq.size();
        chk("bhr", 32'(bhr), 32'(m_bhr));
        chk("count", 32'(count), 32'(sz));
        chk("pred_ready", 32'(pred_ready), 32'(sz < 8));
        chk("pred_tag", 32'(pred_tag), 32'((m_head + sz) % 8));
        chk("retire_ready", 32'(retire_ready), 32'((sz > 0) && mq[0].res));
        chk("mispredict", 32'(mispredict), 32'(e_mis));
        if (e_mis) chk("mispredict_tag", 32'(mispredict_tag), 32'(e_mtag));
        chk("wr_en", 32'(wr_en), 32'(e_wr));
        if (e_wr) begin
            chk("wr_taken", 32'(wr_taken), 32'(e_wrt));
            chk("wr_index", 32'(wr_index), 32'(e_wri));
        end
    endtask

    task automatic cyc(input logic pv, input logic pt, input logic [3:0] pidx,
                       input logic rv, input logic [2:0] rtag, input logic rt,
                       input logic retv);
        pred_valid    = pv;
        pred_taken    = pt;
        pred_index    = pidx;
        resolve_valid = rv;
        resolve_tag   = rtag;
        resolve_taken = rt;
        retire_valid  = retv;
        model_step(pv, pt, pidx, rv, rtag, rt, retv);
        @(posedge clock);
        #1;
        check_model();
    endtask

    task automatic check_reset_vals(input string where);
        chk({where, " bhr"}, 32'(bhr), 32'd0);
        chk({where, " count"}, 32'(count), 32'd0);
        chk({where, " pred_ready"}, 32'(pred_ready), 32'd1);
        chk({where, " pred_tag"}, 32'(pred_tag), 32'd0);
        chk({where, " retire_ready"}, 32'(retire_ready), 32'd0);
        chk({where, " mispredict"}, 32'(mispredict), 32'd0);
        chk({where, " wr_en"}, 32'(wr_en), 32'd0);
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, then releases.
    task automatic do_reset();
        pred_valid    = 1'b0;
        pred_taken    = 1'b0;
        pred_index    = 4'd0;
        resolve_valid = 1'b0;
        resolve_tag   = 3'd0;
        resolve_taken = 1'b0;
        retire_valid  = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("async_rst");
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    typedef struct {
        logic       pv, pt;
        logic [3:0] pidx;
        logic       rv;
        logic [2:0] rtag;
        logic       rt, retv;
        logic [3:0] e_bhr;
        int         e_cnt;
        logic       e_rr, e_mis, e_wr, e_wrt;
        logic [3:0] e_wri;
        logic [2:0] e_tag;
    } vec_t;

    vec_t tbl[9];

    initial begin
        reset         = 1'b0;
        pred_valid    = 1'b0;
        pred_taken    = 1'b0;
        pred_index    = 4'd0;
        resolve_valid = 1'b0;
        resolve_tag   = 3'd0;
        resolve_taken = 1'b0;
        retire_valid  = 1'b0;
        model_clear();

        // History shift, mispredict restore, training writes, then alloc+retire overlap.
        tbl[0] = '{1, 1, 4'd3, 0, 3'd0, 0, 0, 4'b0001, 1, 0, 0, 0, 0, 4'd0, 3'd1};
        tbl[1] = '{1, 0, 4'd4, 0, 3'd0, 0, 0, 4'b0010, 2, 0, 0, 0, 0, 4'd0, 3'd2};
        tbl[2] = '{1, 1, 4'd5, 0, 3'd0, 0, 0, 4'b0101, 3, 0, 0, 0, 0, 4'd0, 3'd3};
        tbl[3] = '{1, 1, 4'd6, 0, 3'd0, 0, 0, 4'b1011, 4, 0, 0, 0, 0, 4'd0, 3'd4};
        tbl[4] = '{0, 0, 4'd0, 1, 3'd1, 1, 0, 4'b0011, 2, 0, 1, 0, 0, 4'd0, 3'd2};
        tbl[5] = '{0, 0, 4'd0, 1, 3'd0, 1, 0, 4'b0011, 2, 1, 0, 0, 0, 4'd0, 3'd2};
        tbl[6] = '{0, 0, 4'd0, 0, 3'd0, 0, 1, 4'b0011, 1, 1, 0, 1, 1, 4'd3, 3'd2};
        tbl[7] = '{1, 0, 4'd7, 0, 3'd0, 0, 1, 4'b0110, 1, 0, 0, 1, 1, 4'd4, 3'd3};
        tbl[8] = '{0, 0, 4'd0, 0, 3'd0, 0, 0, 4'b0110, 1, 0, 0, 0, 0, 4'd0, 3'd3};

        repeat (2) @(posedge clock);
        #1;
        check_reset_vals("in_reset");
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_reset_vals("post_reset");

        for (int i = 0; i < 9; i++) begin
            cyc(tbl[i].pv, tbl[i].pt, tbl[i].pidx, tbl[i].rv, tbl[i].rtag, tbl[i].rt, tbl[i].retv);
            chk($sformatf("vec%0d bhr", i), 32'(bhr), 32'(tbl[i].e_bhr));
            chk($sformatf("vec%0d count", i), 32'(count), 32'(tbl[i].e_cnt));
            chk($sformatf("vec%0d retire_ready", i), 32'(retire_ready), 32'(tbl[i].e_rr));
            chk($sformatf("vec%0d mispredict", i), 32'(mispredict), 32'(tbl[i].e_mis));
            if (tbl[i].e_mis) chk($sformatf("vec%0d mis_tag", i), 32'(mispredict_tag), 32'(tbl[i].rtag));
            chk($sformatf("vec%0d wr_en", i), 32'(wr_en), 32'(tbl[i].e_wr));
            if (tbl[i].e_wr) begin
                chk($sformatf("vec%0d wr_taken", i), 32'(wr_taken), 32'(tbl[i].e_wrt));
                chk($sformatf("vec%0d wr_index", i), 32'(wr_index), 32'(tbl[i].e_wri));
            end
            chk($sformatf("vec%0d pred_tag", i), 32'(pred_tag), 32'(tbl[i].e_tag));
        end

        // Full and wrap: eight allocations fill the buffer, then retire one and reuse slot 0.
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1, 1'(i), 4'(i), 0, 0, 0, 0);
        chk("full pred_ready", 32'(pred_ready), 32'd0);
        chk("full count", 32'(count), 32'd8);
        cyc(1, 1, 4'd9, 0, 0, 0, 0);
        chk("full no alloc count", 32'(count), 32'd8);
        cyc(0, 0, 4'd0, 1, 3'd0, 0, 0);
        cyc(0, 0, 4'd0, 0, 3'd0, 0, 1);
        chk("wrap count", 32'(count), 32'd7);
        chk("wrap pred_tag", 32'(pred_tag), 32'd0);
        chk("wrap wr_index", 32'(wr_index), 32'd0);
        cyc(1, 1, 4'd12, 0, 0, 0, 0);
        chk("wrap refill count", 32'(count), 32'd8);
        chk("wrap next tag", 32'(pred_tag), 32'd1);

        // Mispredict beats a same-cycle allocation.
        do_reset();
        cyc(1, 1, 4'd1, 0, 0, 0, 0);
        cyc(1, 1, 4'd2, 0, 0, 0, 0);
        chk("pre_squash bhr", 32'(bhr), 32'b0011);
        cyc(1, 1, 4'd9, 1, 3'd0, 0, 0);
        chk("squash bhr", 32'(bhr), 32'd0);
        chk("squash count", 32'(count), 32'd1);
        chk("squash mispredict", 32'(mispredict), 32'd1);
        chk("squash pred_tag", 32'(pred_tag), 32'd1);
        cyc(0, 0, 4'd0, 0, 0, 0, 0);
        chk("mispredict pulse", 32'(mispredict), 32'd0);

        // Randomized traffic against the queue model, with one mid-run reset.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            cyc(1'($urandom_range(0, 9) < 6), 1'($urandom), 4'($urandom),
                1'($urandom_range(0, 9) < 4), 3'($urandom), 1'($urandom),
                1'($urandom_range(0, 9) < 6));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
